// File: rtl/spi_frame_gen_if.sv
// Bundles the SPI pins, pattern controls and status of spi_frame_gen.
// The master modport is the generator side; the slave modport is the device/bench side.
interface spi_frame_gen_if #(
    parameter int unsigned DATA_W = 8
);
    logic              enable;
    logic [1:0]        pattern_mode;
    logic [DATA_W-1:0] seed;
    logic              cs_n;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_done;
    logic              busy;
    logic [7:0]        word_idx;

    modport master (
        input  enable, pattern_mode, seed, mosi,
        output cs_n, sck, miso, rx_data, rx_valid, frame_done, busy, word_idx
    );

    modport slave (
        output enable, pattern_mode, seed, mosi,
        input  cs_n, sck, miso, rx_data, rx_valid, frame_done, busy, word_idx
    );
endinterface

// File: rtl/spi_frame_gen.sv
// SPI mode-0 frame generator: framed bursts of pattern words on MISO, full-duplex MOSI capture.
// SCK is a divided register output; every output is registered.
module spi_frame_gen #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned WORDS_PER_FRAME = 10,
    parameter int unsigned SCK_HALF        = 1,
    parameter int unsigned CS_IDLE         = 1,
    parameter int unsigned GAP_CYCLES      = 100,
    parameter int unsigned LSB_FIRST       = 1
) (
    input logic             clk,
    input logic             rst_n,
    spi_frame_gen_if.master io_spi
);
    localparam bit          Lsb     = (LSB_FIRST != 0);
    localparam int unsigned BitW    = $clog2(DATA_W);
    localparam int unsigned CntMax0 = (GAP_CYCLES > 2 * SCK_HALF) ? GAP_CYCLES : 2 * SCK_HALF;
    localparam int unsigned CntMax  = (CS_IDLE > CntMax0) ? CS_IDLE : CntMax0;
    localparam int unsigned CntW    = $clog2(CntMax);

    localparam logic [CntW-1:0] HalfEnd  = CntW'(SCK_HALF - 1);
    localparam logic [CntW-1:0] LowEnd   = CntW'(2 * SCK_HALF - 1);
    localparam logic [CntW-1:0] WgapEnd  = CntW'(CS_IDLE - 1);
    localparam logic [CntW-1:0] FgapEnd  = CntW'(GAP_CYCLES - 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(DATA_W - 1);
    localparam logic [7:0]      LastWord = 8'(WORDS_PER_FRAME - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StWgap, StFgap} state_t;

    state_t            r_state;
    logic [CntW-1:0]   r_cnt;
    logic [BitW-1:0]   r_bit;
    logic [DATA_W-1:0] r_pattern;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic [7:0]        r_word_idx;
    logic              r_cs_n;
    logic              r_sck;
    logic              r_miso;
    logic              r_rx_valid;
    logic              r_frame_done;
    logic              r_busy;

    logic [DATA_W-1:0] w_seed_eff;
    logic [DATA_W-1:0] w_pat_next;
    logic [DATA_W-1:0] w_rx_shift;
    logic [BitW-1:0]   w_next_bit;
    logic              w_miso_next;
    logic              w_seed_first;
    logic              w_pat_first;

    always_comb begin
        // A zero seed would make the walking-one pattern stay empty forever
        w_seed_eff = (io_spi.pattern_mode == 2'd3 && io_spi.seed == '0) ? DATA_W'(1)
                                                                        : io_spi.seed;
        unique case (io_spi.pattern_mode)
            2'd0:    w_pat_next = r_pattern + 1'b1;
            2'd1:    w_pat_next = r_pattern - 1'b1;
            2'd2:    w_pat_next = r_pattern;
            default: w_pat_next = {r_pattern[DATA_W-2:0], r_pattern[DATA_W-1]};
        endcase
        w_rx_shift   = Lsb ? {io_spi.mosi, r_rx_sh[DATA_W-1:1]}
                           : {r_rx_sh[DATA_W-2:0], io_spi.mosi};
        w_next_bit   = r_bit + 1'b1;
        w_miso_next  = Lsb ? r_pattern[w_next_bit] : r_pattern[LastBit - w_next_bit];
        w_seed_first = Lsb ? w_seed_eff[0] : w_seed_eff[DATA_W-1];
        w_pat_first  = Lsb ? r_pattern[0] : r_pattern[DATA_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_pattern    <= '0;
            r_rx_sh      <= '0;
            r_rx_data    <= '0;
            r_word_idx   <= '0;
            r_cs_n       <= 1'b1;
            r_sck        <= 1'b0;
            r_miso       <= 1'b1;
            r_rx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_spi.enable) begin
                        r_pattern  <= w_seed_eff;
                        r_word_idx <= '0;
                        r_cnt      <= '0;
                        r_cs_n     <= 1'b0;
                        r_sck      <= 1'b0;
                        r_miso     <= w_seed_first;
                        r_busy     <= 1'b1;
                        r_state    <= StSetup;
                    end
                end
                StSetup: begin
                    if (r_cnt == HalfEnd) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_sck   <= 1'b1;
                        r_rx_sh <= w_rx_shift;
                        r_state <= StShift;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StShift: begin
                    // r_cnt runs through the high phase and on into the low phase of a bit
                    if (r_sck) begin
                        if (r_cnt == HalfEnd) begin
                            r_sck <= 1'b0;
                            if (r_bit != LastBit) r_miso <= w_miso_next;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end else if (r_cnt == LowEnd) begin
                        r_cnt <= '0;
                        if (r_bit == LastBit) begin
                            r_cs_n     <= 1'b1;
                            r_miso     <= 1'b1;
                            r_rx_data  <= r_rx_sh;
                            r_rx_valid <= 1'b1;
                            r_pattern  <= w_pat_next;
                            r_state    <= StWgap;
                        end else begin
                            r_bit   <= w_next_bit;
                            r_sck   <= 1'b1;
                            r_rx_sh <= w_rx_shift;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWgap: begin
                    if (r_cnt == WgapEnd) begin
                        r_cnt <= '0;
                        if (r_word_idx == LastWord) begin
                            r_frame_done <= 1'b1;
                            r_word_idx   <= '0;
                            r_state      <= StFgap;
                        end else begin
                            r_word_idx <= r_word_idx + 8'd1;
                            if (io_spi.enable) begin
                                r_cs_n  <= 1'b0;
                                r_miso  <= w_pat_first;
                                r_state <= StSetup;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= StIdle;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StFgap: begin
                    if (r_cnt == FgapEnd) begin
                        r_cnt <= '0;
                        if (io_spi.enable) begin
                            r_cs_n  <= 1'b0;
                            r_miso  <= w_pat_first;
                            r_state <= StSetup;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_spi.cs_n       = r_cs_n;
    assign io_spi.sck        = r_sck;
    assign io_spi.miso       = r_miso;
    assign io_spi.rx_data    = r_rx_data;
    assign io_spi.rx_valid   = r_rx_valid;
    assign io_spi.frame_done = r_frame_done;
    assign io_spi.busy       = r_busy;
    assign io_spi.word_idx   = r_word_idx;
endmodule

// File: tb/tb_spi_frame_gen.sv
// Directed bench for spi_frame_gen: a default 8-bit LSB-first instance and a 16-bit MSB-first
// instance, with MISO words and rx_data scoreboarded against queues filled at stimulus time.
`timescale 1ns/1ps
module tb_spi_frame_gen;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_frame_gen_if #(.DATA_W(8))  s0 ();
    spi_frame_gen_if #(.DATA_W(16)) s1 ();

    logic loop_en = 1'b0;
    logic mosi0   = 1'b0;
    assign s0.mosi = loop_en ? s0.miso : mosi0;

    spi_frame_gen #(.DATA_W(8)) u0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_spi (s0)
    );

    spi_frame_gen #(.DATA_W(16), .SCK_HALF(3), .LSB_FIRST(0)) u1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_spi (s1)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          fd_cnt  = 0;
    bit          mon_en  = 1'b1;
    logic [31:0] q_tx[$];
    logic [31:0] q_rx[$];
    logic [31:0] q1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reassembles each 8-bit MISO word between CS_N edges and checks rx_valid payloads
    initial begin : mon0
        logic [7:0] w;
        int         low;
        logic       sck_q;
        logic       cs_q;
        w = '0; low = 0; sck_q = 1'b0; cs_q = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                low = 0;
            end else begin
                if (!s0.cs_n) begin
                    low++;
                    if (s0.sck && !sck_q) w = {s0.miso, w[7:1]};
                end else if (!cs_q) begin
                    if (mon_en) begin
                        check("tx_q_nonempty", 32'(q_tx.size() > 0), 1);
                        if (q_tx.size() > 0) check("miso_word", 32'(w), q_tx.pop_front());
                        check("cs_low_cycles", 32'(low), 17);
                        check("out_no_x", 32'($isunknown({s0.cs_n, s0.sck, s0.miso, s0.rx_data,
                              s0.rx_valid, s0.frame_done, s0.busy, s0.word_idx})), 0);
                    end
                    low = 0;
                end
                if (s0.rx_valid) begin
                    check("rx_q_nonempty", 32'(q_rx.size() > 0), 1);
                    if (q_rx.size() > 0) check("rx_data", 32'(s0.rx_data), q_rx.pop_front());
                end
                if (s0.frame_done) fd_cnt++;
            end
            sck_q = s0.sck;
            cs_q  = s0.cs_n;
        end
    end

    task automatic cap1(output logic [15:0] w, output int low, output int per);
        int   t;
        int   r0;
        int   rises;
        logic sck_q;
        w = '0; low = 0; per = 0; t = 0; r0 = 0; rises = 0; sck_q = 1'b0;
        while (s1.cs_n && t < 200) begin @(negedge clk); t++; end
        check("cap1_start", 32'(t < 200), 1);
        while (!s1.cs_n && low < 300) begin
            low++;
            if (s1.sck && !sck_q) begin
                w = {w[14:0], s1.miso};
                rises++;
                if (rises == 1) r0 = low;
                if (rises == 2) per = low - r0;
            end
            sck_q = s1.sck;
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          t;
        int          n;
        int          low;
        int          per;
        logic [7:0]  v;
        logic [15:0] w16;
        s0.enable = 1'b0; s0.pattern_mode = 2'd0; s0.seed = 8'h00;
        s1.enable = 1'b0; s1.pattern_mode = 2'd1; s1.seed = 16'h0000; s1.mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(s0.cs_n), 1);
        check("rst_sck", 32'(s0.sck), 0);
        check("rst_miso", 32'(s0.miso), 1);
        check("rst_rx_data", 32'(s0.rx_data), 0);
        check("rst_flags", 32'({s0.rx_valid, s0.frame_done, s0.busy}), 0);
        check("rst_word_idx", 32'(s0.word_idx), 0);
        check("rst1_cs_n", 32'(s1.cs_n), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Incrementing pattern, full frame plus five words, enable dropped in word 4
        for (int i = 0; i < 15; i++) begin q_tx.push_back(32'(i)); q_rx.push_back(0); end
        s0.enable = 1'b1;
        @(negedge clk);
        check("start_busy", 32'(s0.busy), 1);
        check("start_cs_n", 32'(s0.cs_n), 0);
        t = 0;
        while (!s0.frame_done && t < 400) begin @(negedge clk); t++; end
        check("fd_seen", 32'(t < 400), 1);
        check("fd_word_idx", 32'(s0.word_idx), 0);
        check("fd_no_rx_valid", 32'(s0.rx_valid), 0);
        n = 1;
        while (s0.cs_n && n < 300) begin @(negedge clk); if (s0.cs_n) n++; end
        check("frame_gap", 32'(n), 100);
        t = 0;
        while (!(s0.word_idx == 8'd4 && !s0.cs_n) && t < 200) begin @(negedge clk); t++; end
        check("word4_seen", 32'(t < 200), 1);
        repeat (7) @(negedge clk);
        check("bit3_sck_high", 32'(s0.sck), 1);
        s0.enable = 1'b0;
        t = 0;
        while (s0.busy && t < 100) begin @(negedge clk); t++; end
        check("stop_busy_low", 32'(t < 100), 1);
        check("stop_word_idx", 32'(s0.word_idx), 5);
        check("stop_fd_count", 32'(fd_cnt), 1);
        check("stop_tx_q_empty", 32'(q_tx.size()), 0);
        repeat (5) @(negedge clk);
        check("stop_cs_high", 32'(s0.cs_n), 1);

        // Walking one with MOSI looped back; seed written after start must be ignored
        loop_en = 1'b1; s0.pattern_mode = 2'd3; s0.seed = 8'h01;
        v = 8'h01;
        for (int i = 0; i < 10; i++) begin
            q_tx.push_back(32'(v)); q_rx.push_back(32'(v));
            v = {v[6:0], v[7]};
        end
        s0.enable = 1'b1;
        @(negedge clk);
        check("restart_word_idx", 32'(s0.word_idx), 0);
        s0.seed = 8'h55;
        t = 0;
        while (!s0.frame_done && t < 400) begin @(negedge clk); t++; end
        check("fd2_seen", 32'(t < 400), 1);
        s0.enable = 1'b0;
        t = 0;
        while (s0.busy && t < 300) begin @(negedge clk); t++; end
        check("loop_idle", 32'(t < 300), 1);
        check("loop_rx_q_empty", 32'(q_rx.size()), 0);
        check("loop_fd_count", 32'(fd_cnt), 2);

        // Decrement-free wrap 0xFE,0xFF,0x00 then async reset mid-word with SCK high
        loop_en = 1'b0; s0.pattern_mode = 2'd0; s0.seed = 8'hFE;
        foreach (q_tx[i]) q_tx.delete(i);
        q_tx.push_back(32'hFE); q_tx.push_back(32'hFF); q_tx.push_back(32'h00);
        for (int i = 0; i < 3; i++) q_rx.push_back(0);
        s0.enable = 1'b1;
        t = 0;
        while (q_tx.size() != 0 && t < 200) begin @(negedge clk); t++; end
        check("wrap_words_done", 32'(t < 200), 1);
        t = 0;
        while (!(!s0.cs_n && s0.sck) && t < 20) begin @(negedge clk); t++; end
        check("wrap_sck_high", 32'(t < 20), 1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs_n", 32'(s0.cs_n), 1);
        check("arst_sck", 32'(s0.sck), 0);
        check("arst_miso", 32'(s0.miso), 1);
        check("arst_busy_rxv", 32'({s0.busy, s0.rx_valid}), 0);
        s0.seed = 8'h10;
        q_tx.push_back(32'h10); q_rx.push_back(0);
        @(negedge clk);
        #1 rst_n = 1'b1; mon_en = 1'b1;
        @(negedge clk);
        check("rel_cs_n", 32'(s0.cs_n), 0);
        check("rel_busy", 32'(s0.busy), 1);
        check("rel_miso_first", 32'(s0.miso), 0);
        s0.enable = 1'b0;
        t = 0;
        while (s0.busy && t < 100) begin @(negedge clk); t++; end
        check("rel_idle", 32'(t < 100), 1);
        check("rel_tx_q_empty", 32'(q_tx.size()), 0);
        check("rel_rx_q_empty", 32'(q_rx.size()), 0);

        // 16-bit MSB-first, SCK_HALF=3, decrementing from 0x0000
        q1.push_back(32'h0000); q1.push_back(32'hFFFF); q1.push_back(32'hFFFE);
        s1.enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cap1(w16, low, per);
            if (k == 2) s1.enable = 1'b0;
            check("w16_word", 32'(w16), q1.pop_front());
            check("w16_cs_low", 32'(low), 99);
            check("w16_sck_period", 32'(per), 6);
        end
        t = 0;
        while (s1.busy && t < 50) begin @(negedge clk); t++; end
        check("w16_idle", 32'(t < 50), 1);
        check("w16_word_idx", 32'(s1.word_idx), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
